// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vend controller, hopper and change dispenser.
interface change_dispenser_if;
  logic       i_start;
  logic [4:0] i_change;
  logic [2:0] i_empty;
  logic       i_eject_ack;
  logic [2:0] o_eject;
  logic       o_busy;
  logic       o_done;
  logic [4:0] o_remain;
  logic       o_shortfall;
  logic [2:0] o_fault;
  logic [4:0] o_coins;

  modport master (
    output i_start, i_change, i_empty, i_eject_ack,
    input  o_eject, o_busy, o_done, o_remain, o_shortfall, o_fault, o_coins
  );

  modport slave (
    input  i_start, i_change, i_empty, i_eject_ack,
    output o_eject, o_busy, o_done, o_remain, o_shortfall, o_fault, o_coins
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy largest-coin-first payout over a three-tube hopper, one acked coin at a time,
// with per-tube ack timeout and empty-tube skipping.
module change_dispenser #(
  parameter int unsigned DENOM0      = 1,
  parameter int unsigned DENOM1      = 5,
  parameter int unsigned DENOM2      = 10,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  localparam int unsigned CntMax = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [4:0]  D0     = 5'(DENOM0);
  localparam logic [4:0]  D1     = 5'(DENOM1);
  localparam logic [4:0]  D2     = 5'(DENOM2);

  typedef enum logic [2:0] {StIdle, StSelect, StWaitAck, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        remain_q, remain_d;
  logic [4:0]        coins_q, coins_d;
  logic [2:0]        fault_q, fault_d;
  logic [2:0]        eject_q, eject_d;
  logic              shortfall_q, shortfall_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        sel;
  logic [4:0]        eject_denom;

  // Highest usable tube whose coin still fits in the remaining amount.
  always_comb begin
    sel = 3'b000;
    if (remain_q >= D2 && !bus.i_empty[2] && !fault_q[2]) begin
      sel = 3'b100;
    end else if (remain_q >= D1 && !bus.i_empty[1] && !fault_q[1]) begin
      sel = 3'b010;
    end else if (remain_q >= D0 && !bus.i_empty[0] && !fault_q[0]) begin
      sel = 3'b001;
    end
  end

  always_comb begin
    eject_denom = D0;
    if (eject_q[2]) begin
      eject_denom = D2;
    end else if (eject_q[1]) begin
      eject_denom = D1;
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    coins_d     = coins_q;
    fault_d     = fault_q;
    eject_d     = eject_q;
    shortfall_d = shortfall_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          remain_d    = bus.i_change;
          coins_d     = 5'd0;
          fault_d     = 3'b000;
          shortfall_d = 1'b0;
          state_d     = (bus.i_change != 5'd0) ? StSelect : StDone;
        end
      end
      StSelect: begin
        if (remain_q != 5'd0 && sel != 3'b000) begin
          eject_d = sel;
          cnt_d   = '0;
          state_d = StWaitAck;
        end else begin
          state_d = StDone;
        end
      end
      StWaitAck: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (bus.i_eject_ack) begin
          remain_d = remain_q - eject_denom;
          coins_d  = coins_q + 5'd1;
          eject_d  = 3'b000;
          cnt_d    = '0;
          state_d  = StGap;
        end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
          fault_d = fault_q | eject_q;
          eject_d = 3'b000;
          state_d = StSelect;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StSelect;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        shortfall_d = (remain_q != 5'd0);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remain_q    <= 5'd0;
      coins_q     <= 5'd0;
      fault_q     <= 3'b000;
      eject_q     <= 3'b000;
      shortfall_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      coins_q     <= coins_d;
      fault_q     <= fault_d;
      eject_q     <= eject_d;
      shortfall_q <= shortfall_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_eject     = eject_q;
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_done      = (state_q == StDone);
  assign bus.o_remain    = remain_q;
  assign bus.o_shortfall = shortfall_q;
  assign bus.o_fault     = fault_q;
  assign bus.o_coins     = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboarded bench for change_dispenser: expected eject sequence is queued at start,
// a monitor pops and compares each new eject, and per-scenario tasks check final status.
module tb_change_dispenser;

  logic clk;
  logic reset;
  change_dispenser_if bus ();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  logic [2:0] exp_q[$];
  logic [2:0] no_ack_mask = 3'b000;

  // Hopper model: acks the third sample of a held eject unless that tube is blocked.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.i_eject_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_eject_ack = 1'b0;
      if (!reset && bus.o_eject != 3'b000 && (bus.o_eject & no_ack_mask) == 3'b000) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          bus.i_eject_ack = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every newly asserted eject must match the head of the scoreboard.
  initial begin
    logic [2:0] prev;
    logic [2:0] exp;
    prev = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_done) done_cnt++;
      if (bus.o_eject != 3'b000 && bus.o_eject != prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL eject_seq: unexpected eject %b, none expected", bus.o_eject);
        end else begin
          exp = exp_q.pop_front();
          if (bus.o_eject !== exp) begin
            n_fail++;
            $display("FAIL eject_seq: got %b, expected %b", bus.o_eject, exp);
          end
        end
      end
      prev = bus.o_eject;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [4:0] change);
    bus.i_start  = 1'b1;
    bus.i_change = change;
    step();
    bus.i_start  = 1'b0;
    bus.i_change = 5'd0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < max_cyc) begin
      if (bus.o_done) begin
        ok = 1'b1;
        return;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({bus.o_eject, bus.o_busy, bus.o_done, bus.o_shortfall} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: eject=%b busy=%b done=%b short=%b, expected all 0",
               bus.o_eject, bus.o_busy, bus.o_done, bus.o_shortfall);
    end
    n_checks++;
    if ({bus.o_remain, bus.o_coins, bus.o_fault} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_data: remain=%0d coins=%0d fault=%b, expected 0 0 000",
               bus.o_remain, bus.o_coins, bus.o_fault);
    end
  endtask

  task automatic test_greedy();
    int cyc;
    bit ok;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    drive_start(5'd17);
    n_checks++;
    if (bus.o_busy !== 1'b1 || bus.o_eject !== 3'b000) begin
      n_fail++;
      $display("FAIL greedy_select: busy=%b eject=%b, expected 1 000", bus.o_busy, bus.o_eject);
    end
    step();
    n_checks++;
    if (bus.o_eject !== 3'b100) begin
      n_fail++;
      $display("FAIL greedy_latency: eject=%b two cycles after start, expected 100", bus.o_eject);
    end
    wait_done(300, cyc, ok);
    n_checks++;
    if (!ok || bus.o_coins !== 5'd4 || bus.o_remain !== 5'd0) begin
      n_fail++;
      $display("FAIL greedy_result: done=%b coins=%0d remain=%0d, expected 1 4 0",
               ok, bus.o_coins, bus.o_remain);
    end
    step();
    n_checks++;
    if (bus.o_shortfall !== 1'b0 || bus.o_busy !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL greedy_end: short=%b busy=%b dones=%0d, expected 0 0 1",
               bus.o_shortfall, bus.o_busy, done_cnt - d0);
    end
  endtask

  task automatic test_empty_tube();
    int cyc;
    bit ok;
    bus.i_empty = 3'b010;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'b001);
    drive_start(5'd8);
    wait_done(500, cyc, ok);
    n_checks++;
    if (!ok || bus.o_coins !== 5'd8 || bus.o_remain !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_tube: done=%b coins=%0d remain=%0d, expected 1 8 0",
               ok, bus.o_coins, bus.o_remain);
    end
    step();
    bus.i_empty = 3'b000;
  endtask

  task automatic test_no_coin();
    int cyc;
    bit ok;
    bus.i_empty = 3'b001;
    drive_start(5'd3);
    wait_done(10, cyc, ok);
    n_checks++;
    if (!ok || cyc + 1 > 3) begin
      n_fail++;
      $display("FAIL no_coin_done: seen=%b after %0d cycles, expected within 3", ok, cyc + 1);
    end
    step();
    n_checks++;
    if (bus.o_shortfall !== 1'b1 || bus.o_remain !== 5'd3 || bus.o_coins !== 5'd0) begin
      n_fail++;
      $display("FAIL no_coin_result: short=%b remain=%0d coins=%0d, expected 1 3 0",
               bus.o_shortfall, bus.o_remain, bus.o_coins);
    end
    bus.i_empty = 3'b000;
  endtask

  task automatic test_timeout();
    int cyc;
    int held;
    bit ok;
    no_ack_mask = 3'b100;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b010);
    drive_start(5'd10);
    step();
    held = 0;
    while (bus.o_eject == 3'b100 && held < 200) begin
      held++;
      step();
    end
    n_checks++;
    if (held != 64) begin
      n_fail++;
      $display("FAIL timeout_len: eject held %0d cycles, expected 64", held);
    end
    wait_done(300, cyc, ok);
    n_checks++;
    if (!ok || bus.o_fault !== 3'b100 || bus.o_coins !== 5'd2 || bus.o_remain !== 5'd0) begin
      n_fail++;
      $display("FAIL timeout_result: done=%b fault=%b coins=%0d remain=%0d, expected 1 100 2 0",
               ok, bus.o_fault, bus.o_coins, bus.o_remain);
    end
    step();
    no_ack_mask = 3'b000;
  endtask

  task automatic test_zero();
    drive_start(5'd0);
    n_checks++;
    if (bus.o_done !== 1'b1 || bus.o_fault !== 3'b000) begin
      n_fail++;
      $display("FAIL zero_done: done=%b fault=%b one cycle after start, expected 1 000",
               bus.o_done, bus.o_fault);
    end
    step();
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_shortfall !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_end: busy=%b done=%b short=%b, expected 0 0 0",
               bus.o_busy, bus.o_done, bus.o_shortfall);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    drive_start(5'd6);
    wait_done(300, cyc, ok);
    step();
    drive_start(5'd2);
    n_checks++;
    if (!ok || bus.o_busy !== 1'b1 || bus.o_remain !== 5'd2 || bus.o_coins !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_restart: done=%b busy=%b remain=%0d coins=%0d, expected 1 1 2 0",
               ok, bus.o_busy, bus.o_remain, bus.o_coins);
    end
    wait_done(300, cyc, ok);
    n_checks++;
    if (!ok || bus.o_coins !== 5'd2 || bus.o_remain !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_result: done=%b coins=%0d remain=%0d, expected 1 2 0",
               ok, bus.o_coins, bus.o_remain);
    end
    step();
  endtask

  task automatic test_ignore_and_reset();
    int cyc;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    drive_start(5'd20);
    step();
    step();
    drive_start(5'd5);
    cyc = 0;
    while (!(bus.o_coins == 5'd1 && bus.o_eject != 3'b000) && cyc < 200) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc >= 200 || bus.o_remain !== 5'd10 || bus.o_eject !== 3'b100) begin
      n_fail++;
      $display("FAIL ignore_start: remain=%0d eject=%b, expected 10 100", bus.o_remain,
               bus.o_eject);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.o_eject !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_remain !== 5'd0 || bus.o_coins !== 5'd0 || bus.o_fault !== 3'b000 ||
        bus.o_shortfall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: eject=%b busy=%b remain=%0d coins=%0d, expected all 0",
               bus.o_eject, bus.o_busy, bus.o_remain, bus.o_coins);
    end
    step();
  endtask

  initial begin
    reset        = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_change = 5'd0;
    bus.i_empty  = 3'b000;
    step();
    test_reset();
    test_greedy();
    test_empty_tube();
    test_no_coin();
    test_timeout();
    test_zero();
    test_back_to_back();
    test_ignore_and_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d ejects outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
